vga_timing_param: RTL and testbench

Parametrised VGA timing generator; successor to the fixed-mode timing controller. Produces pixel/line counters, sync and blanking strobes on the `vga_if.out` bundle for any resolution set at elaboration. Adds a pixel clock-enable, programmable sync polarity, and line/frame-start pulses. Sits at the head of the video pipeline, feeding the background, board and sprite drawing stages.

---
 rtl/vga_timing_param_if.sv | 12 +
 rtl/vga_timing_param.sv | 128 ++++++++++++
 tb/tb_vga_timing_param.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_param_if.sv
// vga_if: video timing bundle passed from the timing generator down the drawing pipeline.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk);
  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);
endinterface

// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA timing generator with pixel enable, sync polarity and
// line/frame pulses. Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_param #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  vga_if.out          vga_out,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_err
    $error("vga_timing_param: H_TOTAL or V_TOTAL exceeds 2048");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_err
    $error("vga_timing_param: timing parameters must be at least 1");
  end

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON     = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic        VS_ON     = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [10:0] hcount_q;
  logic [10:0] vcount_q;
  logic        hsync_q;
  logic        hblnk_q;
  logic        vsync_q;
  logic        vblnk_q;

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        hsync_next;
  logic        hblnk_next;
  logic        vsync_next;
  logic        vblnk_next;

  // Strobes are decoded from the count about to be loaded, so they register together with it.
  always_comb begin
    h_wrap     = (hcount_q == H_LAST);
    v_wrap     = (vcount_q == V_LAST);
    h_next     = h_wrap ? 11'd0 : hcount_q + 11'd1;
    v_next     = vcount_q;
    if (h_wrap) begin
      v_next = v_wrap ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_next = (h_next >= H_ACT);
    vblnk_next = (v_next >= V_ACT);
    hsync_next = (h_next >= H_SYNC_LO && h_next < H_SYNC_HI) ? HS_ON : ~HS_ON;
    vsync_next = (v_next >= V_SYNC_LO && v_next < V_SYNC_HI) ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= 11'd0;
      vcount_q    <= 11'd0;
      hsync_q     <= ~HS_ON;
      hblnk_q     <= 1'b0;
      vsync_q     <= ~VS_ON;
      vblnk_q     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hcount_q    <= h_next;
        vcount_q    <= v_next;
        hsync_q     <= hsync_next;
        hblnk_q     <= hblnk_next;
        vsync_q     <= vsync_next;
        vblnk_q     <= vblnk_next;
        line_start  <= h_wrap;
        frame_start <= h_wrap & v_wrap;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Advances on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else if (pix_en && h_wrap && v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.vblnk  = vblnk_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// tb_vga_timing_param: small-mode timing generators (both sync polarities) checked against a
// frame-position model under constant, divided and random pix_en, plus mid-frame reset.
module tb_vga_timing_param;

  localparam int HA = 8;
  localparam int HFP = 2;
  localparam int HS = 3;
  localparam int HBP = 3;
  localparam int VA = 4;
  localparam int VFP = 1;
  localparam int VS = 2;
  localparam int VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;

  vga_if vif_p ();
  vga_if vif_n ();
  logic ls_p, fs_p, ls_n, fs_n;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_p, fc_n;
`endif

  always #5 clk = ~clk;

  vga_timing_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1), .VSYNC_POL(1)
  ) dut_p (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_out(vif_p),
    .line_start(ls_p), .frame_start(fs_p)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_p)
`endif
  );

  vga_timing_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut_n (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_out(vif_n),
    .line_start(ls_n), .frame_start(fs_n)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_n)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: linear position within the frame plus pulse/frame expectations.
  int   pos = 0;
  logic exp_ls = 1'b0;
  logic exp_fs = 1'b0;
  int   exp_fc_p = 0;
  int   exp_fc_n = 0;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s at t=%0t pos=%0d observed=%h expected=%h", tag, $time, pos, obs, expv);
    end
  endtask

  task automatic checkAll();
    int  mh, mv;
    logic hs_act, vs_act;
    mh = pos % HT;
    mv = pos / HT;
    hs_act = (mh >= HA + HFP) && (mh < HA + HFP + HS);
    vs_act = (mv >= VA + VFP) && (mv < VA + VFP + VS);
    checkOutput("hcount", {5'd0, vif_p.hcount}, 16'(mh));
    checkOutput("vcount", {5'd0, vif_p.vcount}, 16'(mv));
    checkOutput("hblnk", {15'd0, vif_p.hblnk}, {15'd0, (mh >= HA)});
    checkOutput("vblnk", {15'd0, vif_p.vblnk}, {15'd0, (mv >= VA)});
    checkOutput("hsync_pos", {15'd0, vif_p.hsync}, {15'd0, hs_act});
    checkOutput("vsync_pos", {15'd0, vif_p.vsync}, {15'd0, vs_act});
    checkOutput("line_start", {15'd0, ls_p}, {15'd0, exp_ls});
    checkOutput("frame_start", {15'd0, fs_p}, {15'd0, exp_fs});
    checkOutput("hcount_neg", {5'd0, vif_n.hcount}, 16'(mh));
    checkOutput("hsync_neg", {15'd0, vif_n.hsync}, {15'd0, ~hs_act});
    checkOutput("vsync_neg", {15'd0, vif_n.vsync}, {15'd0, ~vs_act});
    checkOutput("line_start_neg", {15'd0, ls_n}, {15'd0, exp_ls});
    checkOutput("frame_start_neg", {15'd0, fs_n}, {15'd0, exp_fs});
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkOutput("frame_cnt_pos", fc_p, 16'(exp_fc_p));
    checkOutput("frame_cnt_neg", fc_n, 16'(exp_fc_n));
`endif
  endtask

  task automatic modelReset();
    pos = 0;
    exp_ls = 1'b0;
    exp_fs = 1'b0;
    exp_fc_p = 0;
    exp_fc_n = 0;
  endtask

  task automatic applyStimulus(input logic en);
    pix_en = en;
    @(posedge clk);
    #1;
    if (en) begin
      pos = (pos + 1) % FRAME;
      exp_ls = ((pos % HT) == 0);
      exp_fs = (pos == 0);
      if (exp_fs) begin
        exp_fc_p = (exp_fc_p + 1) % 65536;
        exp_fc_n = (exp_fc_n + 1) % 65536;
      end
    end else begin
      exp_ls = 1'b0;
      exp_fs = 1'b0;
    end
    checkAll();
  endtask

  initial begin
    // Asynchronous reset seen between clock edges.
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    pix_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;

    $display("[TB] two frames with pix_en held high");
    for (int i = 0; i < 2 * FRAME + 5; i++) applyStimulus(1'b1);

    $display("[TB] pix_en divide-by-2");
    for (int i = 0; i < 2 * HT * 3; i++) applyStimulus(i[0] ? 1'b0 : 1'b1);

    $display("[TB] random pix_en");
    for (int i = 0; i < 600; i++) applyStimulus(1'($urandom_range(0, 1)));

    $display("[TB] mid-frame reset");
    while (pos != 5 * HT + 9) applyStimulus(1'b1);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;
    for (int i = 0; i < FRAME + 40; i++) applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    $display("[TB] frame_cnt wrap from 0xFFFF");
    force dut_p.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_p.frame_cnt_q;
    exp_fc_p = 16'hFFFF;
    checkOutput("frame_cnt_forced", fc_p, 16'hFFFF);
    for (int i = 0; i < FRAME + 3; i++) applyStimulus(1'b1);
`endif

    for (int i = 0; i < 50; i++) applyStimulus(1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
